// File: rtl/uart_rx_core.sv
// UART receiver core: 2-flop line synchronizer, start-bit qualification,
// mid-bit sampling of an LSB-first payload, and stop-bit handling with
// one-cycle valid/break pulses. Received data holds between frames.
module uart_rx_core #(
    parameter int BIT_RATE     = 9600,
    parameter int CLK_HZ       = 50_000_000,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic                    uart_rx_break,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data
);

    localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int STOP_CYCLES    = CYCLES_PER_BIT * STOP_BITS;
    // Counter must reach the longest interval, which is the stop wait.
    localparam int CW = (STOP_CYCLES > 1) ? $clog2(STOP_CYCLES) : 1;
    localparam int BW = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

    localparam logic [CW-1:0] HALF_END = CW'(CYCLES_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CYCLES_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_END = CW'(STOP_CYCLES - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(PAYLOAD_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        RECV,
        STOP
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    rxd_meta;
    logic                    rxd_sync;
    logic [CW-1:0]           cyc_cnt;
    logic [BW-1:0]           bit_cnt;
    logic [PAYLOAD_BITS-1:0] shreg;
    logic                    cyc_clr;
    logic                    shift_en;
    logic                    frame_done;

    // Two-flop synchronizer on the asynchronous serial line, idles high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_sync <= rxd_meta;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and per-cycle strobes for the datapath.
    always_comb begin
        state_nxt  = state;
        cyc_clr    = 1'b0;
        shift_en   = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                cyc_clr = 1'b1;
                // Enable only gates new frame starts; a frame in flight
                // always runs to completion.
                if (!rxd_sync && uart_rx_en) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (cyc_cnt == HALF_END) begin
                    cyc_clr   = 1'b1;
                    state_nxt = rxd_sync ? IDLE : RECV;
                end
            end
            RECV: begin
                if (cyc_cnt == BIT_END) begin
                    cyc_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (cyc_cnt == STOP_END) begin
                    cyc_clr    = 1'b1;
                    frame_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Cycle counter timing the half-bit, bit and stop intervals.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_cnt <= '0;
        end else if (cyc_clr) begin
            cyc_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
        end
    end

    // Payload bit counter and LSB-first shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (state == IDLE) begin
            bit_cnt <= '0;
        end else if (shift_en) begin
            bit_cnt <= bit_cnt + 1'b1;
            shreg   <= {rxd_sync, shreg[PAYLOAD_BITS-1:1]};
        end
    end

    // Registered outputs: one-cycle pulses and held payload on frame end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            uart_rx_valid <= 1'b0;
            uart_rx_break <= 1'b0;
            uart_rx_data  <= '0;
        end else begin
            uart_rx_valid <= frame_done;
            uart_rx_break <= frame_done && (shreg == '0) && !rxd_sync;
            if (frame_done) begin
                uart_rx_data <= shreg;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core at 10 clocks per bit.
// Reference model: every frame whose start bit begins while enabled yields
// exactly one record {break, data}; break = (data == 0) && (stop bit == 0).
module tb_uart_rx_core;

    localparam int CPB = 10;

    logic       clk;
    logic       reset;
    logic       uart_rxd;
    logic       uart_rx_en;
    logic       uart_rx_break;
    logic       uart_rx_valid;
    logic [7:0] uart_rx_data;

    int total = 0;
    int bad   = 0;
    int stray_break = 0;

    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];
    logic [7:0] last_data;

    uart_rx_core #(
        .BIT_RATE    (100_000),
        .CLK_HZ      (1_000_000),
        .PAYLOAD_BITS(8),
        .STOP_BITS   (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .uart_rxd     (uart_rxd),
        .uart_rx_en   (uart_rx_en),
        .uart_rx_break(uart_rx_break),
        .uart_rx_valid(uart_rx_valid),
        .uart_rx_data (uart_rx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every output pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (uart_rx_valid) got_q.push_back({uart_rx_break, uart_rx_data});
        if (uart_rx_break && !uart_rx_valid) stray_break++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic line_bit(input logic v);
        uart_rxd = v;
        cycles(CPB);
    endtask

    // Drive one frame; optionally drop enable right after the start bit.
    task automatic send_frame(input logic [7:0] d, input logic stop_val,
                              input int gap_bits, input logic drop_en);
        line_bit(1'b0);
        if (drop_en) uart_rx_en = 1'b0;
        for (int i = 0; i < 8; i++) line_bit(d[i]);
        line_bit(stop_val);
        uart_rxd = 1'b1;
        cycles(gap_bits * CPB);
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic stop_val);
        exp_q.push_back({(d == 8'h00) && !stop_val, d});
        last_data = d;
    endtask

    task automatic check_rx(input string tag);
        int n;
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_rec"}, {23'd0, got_q[i]}, {23'd0, exp_q[i]});
        chk({tag, "_hold"}, {24'd0, uart_rx_data}, {24'd0, last_data});
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] d;
        logic       stop_val;
        logic       en_on;
        int         gap;

        uart_rxd   = 1'b1;
        uart_rx_en = 1'b1;
        reset      = 1'b1;
        last_data  = 8'h00;
        cycles(3);
        chk("rst_valid", {31'd0, uart_rx_valid}, 32'd0);
        chk("rst_break", {31'd0, uart_rx_break}, 32'd0);
        chk("rst_data", {24'd0, uart_rx_data}, 32'd0);
        reset = 1'b0;

        // First frame immediately after reset release.
        send_frame(8'hA5, 1'b1, 1, 1'b0);
        expect_frame(8'hA5, 1'b1);
        check_rx("a5");

        // Break frame: zero payload, stop bit low.
        send_frame(8'h00, 1'b0, 2, 1'b0);
        expect_frame(8'h00, 1'b0);
        check_rx("break");

        // Non-zero payload with stop low still yields a plain valid.
        send_frame(8'h40, 1'b0, 2, 1'b0);
        expect_frame(8'h40, 1'b0);
        check_rx("ferr");

        // Three-cycle low glitch on the idle line, then a normal frame.
        uart_rxd = 1'b0;
        cycles(3);
        uart_rxd = 1'b1;
        cycles(3 * CPB);
        check_rx("glitch");
        send_frame(8'h81, 1'b1, 1, 1'b0);
        expect_frame(8'h81, 1'b1);
        check_rx("post_glitch");

        // Back-to-back frames.
        send_frame(8'h55, 1'b1, 0, 1'b0);
        expect_frame(8'h55, 1'b1);
        send_frame(8'hAA, 1'b1, 1, 1'b0);
        expect_frame(8'hAA, 1'b1);
        check_rx("b2b");

        // Reset in the middle of bit 4 of 0xFF abandons the frame.
        line_bit(1'b0);
        for (int i = 0; i < 4; i++) line_bit(1'b1);
        uart_rxd = 1'b1;
        cycles(CPB / 2);
        reset = 1'b1;
        cycles(3);
        chk("midrst_data", {24'd0, uart_rx_data}, 32'd0);
        chk("midrst_valid", {31'd0, uart_rx_valid}, 32'd0);
        last_data = 8'h00;
        reset = 1'b0;
        cycles(7 * CPB);
        check_rx("midrst_quiet");
        send_frame(8'h3C, 1'b1, 1, 1'b0);
        expect_frame(8'h3C, 1'b1);
        check_rx("midrst_3c");

        // Receiver disabled: frame ignored, data held.
        uart_rx_en = 1'b0;
        send_frame(8'h12, 1'b1, 2, 1'b0);
        check_rx("disabled");

        // Enable dropped after the start bit: frame still completes.
        uart_rx_en = 1'b1;
        send_frame(8'hC3, 1'b1, 1, 1'b1);
        expect_frame(8'hC3, 1'b1);
        check_rx("en_drop");

        // Randomized frames with random stop level, gaps and enable.
        for (int i = 0; i < 16; i++) begin
            d        = 8'($urandom);
            if (i % 5 == 0) d = 8'h00;
            stop_val = ($urandom % 4) != 0;
            gap      = stop_val ? int'($urandom % 3) : 1 + int'($urandom % 2);
            en_on    = ($urandom % 4) != 0;
            uart_rx_en = en_on;
            send_frame(d, stop_val, gap, 1'b0);
            if (en_on) expect_frame(d, stop_val);
            if (gap == 0) begin
                uart_rxd = 1'b1;
                cycles(CPB);
            end
            check_rx("rand");
        end

        chk("stray_break", stray_break, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BIT_RATE, default 9600, meaning the serial bit rate in bits/s.
REQ-002 SHALL have parameter CLK_HZ, default 50_000_000, meaning the clk frequency in Hz.
REQ-003 SHALL have parameter PAYLOAD_BITS, default 8, meaning the data bits per frame.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning the stop bits per frame.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 reset  input  1  one clock; reset is asynchronous and active-high.
REQ-007 uart_rxd  input  1  asynchronous serial line; idle high.
REQ-008 uart_rx_en  input  1  receive enable; 0 = ignore line, stay IDLE.
REQ-009 uart_rx_break  output  1  one-cycle pulse: break frame received.
REQ-010 uart_rx_valid  output  1  one-cycle pulse: new byte on uart_rx_data.
REQ-011 uart_rx_data  output  PAYLOAD_BITS  last received payload, LSB first on wire.

Function
REQ-012 SHALL compute CYCLES_PER_BIT = CLK_HZ/BIT_RATE (integer divide) and use a counter wide enough for it.
REQ-013 SHALL pass uart_rxd through a 2-flop synchronizer (reset value 1) before any use.
REQ-014 SHALL implement FSM states IDLE, START, RECV, STOP.
REQ-015 IDLE -> START when the synchronized line is 0 and uart_rx_en=1.
REQ-016 START: count CYCLES_PER_BIT/2 cycles, then re-sample; if still 0 -> RECV, else (glitch) -> IDLE.
REQ-017 RECV: sample every CYCLES_PER_BIT cycles (bit centre), shift into data register LSB-first; after PAYLOAD_BITS samples -> STOP.
REQ-018 STOP: wait CYCLES_PER_BIT*STOP_BITS cycles from last data sample, then sample stop bit and -> IDLE.
REQ-019 On the STOP sample: uart_rx_data SHALL load the shifted payload, and uart_rx_valid SHALL be 1 for exactly one cycle.
REQ-020 uart_rx_break SHALL pulse in the same cycle as uart_rx_valid when payload is all-zero and the stop bit sampled 0; otherwise 0.
REQ-021 A stop bit sampled 0 with non-zero payload SHALL still assert uart_rx_valid (no framing-error output).
REQ-022 uart_rx_data SHALL hold its value between frames; it changes only on a valid pulse.
REQ-023 Deasserting uart_rx_en mid-frame SHALL not abort the frame; only new frame starts are blocked.
REQ-024 Back-to-back frames (next start bit immediately after stop) SHALL be received without loss.
REQ-025 Line level during IDLE other than a start edge SHALL have no effect.

Reset
REQ-026 While reset=1: state=IDLE, counters=0, uart_rx_data=0, uart_rx_valid=0, uart_rx_break=0, synchronizer=1.
REQ-027 Reset asserted mid-frame SHALL abandon the frame immediately; no valid pulse for it after release.
REQ-028 First frame SHALL be accepted starting from the first clk after reset deasserts.

Verification (CLK_HZ=1_000_000, BIT_RATE=100_000 -> 10 cycles/bit)
REQ-029 Send 0xA5 with stop=1 -> single uart_rx_valid pulse, uart_rx_data=0xA5, break=0.
REQ-030 Send 0x00 with stop=0 -> valid and break pulse together, data=0x00.
REQ-031 Low glitch of 3 cycles on idle line -> no valid, FSM returns to IDLE.
REQ-032 Send 0x55 then 0xAA back-to-back -> two valid pulses, data 0x55 then 0xAA.
REQ-033 Assert reset during bit 4 of 0xFF, release, send 0x3C -> only one valid, data=0x3C.
REQ-034 uart_rx_en=0, send 0x12 -> no valid, data unchanged.
